// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-precision add/subtract sequencer.
//   Adds or subtracts two WIDTH-bit operands one 16-bit slice per cycle,
//   least-significant slice first, through a single lcu16 adder. The carry
//   is registered between slices. The result and status flags are presented
//   on a valid/ready output.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operation request handshake
//   op_a, op_b, sub, cin  operands and opcode; sampled only on the accept edge
//   out_valid / out_ready result handshake
//   sum, cout, ovf, zero  result, carry out (no-borrow on subtract),
//                         two's-complement overflow, result-is-zero
//   abort                 present only when WIDE_ADD_SEQ_ABORT_EN is defined;
//                         cancels a running or completed operation
// Optional feature macro: WIDE_ADD_SEQ_ABORT_EN

// lcu16: 16-bit two-level carry-lookahead adder (4-bit groups).
module lcu16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c16_o,
  output logic        pg_o,
  output logic        gg_o
);
  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  grp_g_s;
  logic [3:0]  grp_p_s;
  logic [3:0]  grp_c_s;
  logic [15:0] c_s;

  // Bit and group propagate/generate, group carries and the per-bit sum.
  always_comb begin
    g_s = a_i & b_i;
    p_s = a_i ^ b_i;
    grp_g_s = 4'b0000;
    grp_p_s = 4'b0000;
    grp_c_s = 4'b0000;
    c_s = 16'h0000;
    for (int j = 0; j < 4; j++) begin
      grp_g_s[j] = g_s[4*j+3]
                 | (p_s[4*j+3] & g_s[4*j+2])
                 | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
                 | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      grp_p_s[j] = &p_s[4*j +: 4];
    end
    // Group carries come straight from the lookahead unit, not rippled.
    grp_c_s[0] = c_i;
    grp_c_s[1] = grp_g_s[0] | (grp_p_s[0] & c_i);
    grp_c_s[2] = grp_g_s[1] | (grp_p_s[1] & grp_g_s[0])
               | (grp_p_s[1] & grp_p_s[0] & c_i);
    grp_c_s[3] = grp_g_s[2] | (grp_p_s[2] & grp_g_s[1])
               | (grp_p_s[2] & grp_p_s[1] & grp_g_s[0])
               | (grp_p_s[2] & grp_p_s[1] & grp_p_s[0] & c_i);
    gg_o = grp_g_s[3] | (grp_p_s[3] & grp_g_s[2])
         | (grp_p_s[3] & grp_p_s[2] & grp_g_s[1])
         | (grp_p_s[3] & grp_p_s[2] & grp_p_s[1] & grp_g_s[0]);
    pg_o = &grp_p_s;
    c16_o = gg_o | (pg_o & c_i);
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0) begin
          c_s[4*j] = grp_c_s[j];
        end else begin
          c_s[4*j+b] = g_s[4*j+b-1] | (p_s[4*j+b-1] & c_s[4*j+b-1]);
        end
      end
    end
    s_o = p_s ^ c_s;
  end
endmodule

module wide_add_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
`ifdef WIDE_ADD_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NSLICE = WIDTH / 16;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q;
  logic [NSLICE-1:0][15:0] a_q;
  logic [NSLICE-1:0][15:0] b_q;
  logic [NSLICE-1:0][15:0] sum_q;
  logic                    carry_q;
  logic                    zacc_q;
  logic                    cout_q, ovf_q, zero_q;
  logic                    in_ready_q, out_valid_q;

  logic [15:0] slice_sum_s;
  logic        slice_c16_s;
  logic        slice_zero_s;
  logic        last_slice_s;
  logic        accept_s;
  logic        abort_s;
  logic        unused_pg_s;
  logic        unused_gg_s;

`ifdef WIDE_ADD_SEQ_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  lcu16 u_lcu (
    .a_i   (a_q[k_q]),
    .b_i   (b_q[k_q]),
    .c_i   (carry_q),
    .s_o   (slice_sum_s),
    .c16_o (slice_c16_s),
    .pg_o  (unused_pg_s),
    .gg_o  (unused_gg_s)
  );

  assign slice_zero_s = (slice_sum_s == 16'h0000);
  assign last_slice_s = (k_q == KW'(NSLICE - 1));
  assign accept_s     = (state_q == ST_IDLE) && in_valid && in_ready_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Next-state decode; abort outranks out_ready but can never meet an accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (abort_s)           state_d = ST_IDLE;
        else if (last_slice_s) state_d = ST_DONE;
        else                   state_d = ST_RUN;
      end
      ST_DONE: begin
        if (abort_s)        state_d = ST_IDLE;
        else if (out_ready) state_d = ST_IDLE;
        else                state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, operand/result datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      zacc_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            a_q     <= op_a;
            // Subtract is A + ~B + 1; cin is ignored in that case.
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            k_q     <= '0;
            zacc_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_s) begin
            carry_q <= 1'b0;
            k_q     <= '0;
          end else begin
            sum_q[k_q] <= slice_sum_s;
            carry_q    <= slice_c16_s;
            // Zero flag is accumulated slice by slice, never reduced full-width.
            zacc_q     <= zacc_q & slice_zero_s;
            if (last_slice_s) begin
              cout_q <= slice_c16_s;
              ovf_q  <= (a_q[NSLICE-1][15] == b_q[NSLICE-1][15]) &&
                        (slice_sum_s[15] != a_q[NSLICE-1][15]);
              zero_q <= zacc_q & slice_zero_s;
              k_q    <= '0;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        ST_DONE: begin
          if (abort_s) begin
            carry_q <= 1'b0;
            k_q     <= '0;
          end
        end
        default: begin
          k_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq (WIDTH=64): directed vectors with literal
// expectations plus a transaction-level reference model checked every cycle.
module tb_wide_add_seq;
  localparam int WIDTH  = 64;
  localparam int NSLICE = WIDTH / 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] op_a, op_b;
  logic             sub, cin;
  logic             abort;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
`ifdef WIDE_ADD_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  // Reference result packed as {ovf, zero, cout, sum}, from plain arithmetic.
  function automatic logic [WIDTH+2:0] ref_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s, input logic c);
    logic signed [WIDTH:0] sa, sb, sr;
    logic [WIDTH:0]        u;
    logic [WIDTH-1:0]      r;
    logic                  co, ov;
    sa = {a[WIDTH-1], a};
    sb = {b[WIDTH-1], b};
    if (s) begin
      sr = sa - sb;
      r  = a - b;
      co = (a >= b);
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
      sr = sa + sb + $signed({{WIDTH{1'b0}}, c});
      r  = u[WIDTH-1:0];
      co = u[WIDTH];
    end
    ov = (sr[WIDTH] != sr[WIDTH-1]);
    return {ov, (r == '0), co, r};
  endfunction

  // Transaction-level model: ready / countdown / result-held.
  logic             mdl_rdy, mdl_valid, mdl_have;
  int               mdl_cnt;
  logic [WIDTH+2:0] mdl_res, pend_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_rdy   <= 1'b0;
      mdl_valid <= 1'b0;
      mdl_cnt   <= 0;
      mdl_have  <= 1'b1;
      mdl_res   <= '0;
    end else if (mdl_rdy && in_valid) begin
      pend_res <= ref_op(op_a, op_b, sub, cin);
      mdl_rdy  <= 1'b0;
      mdl_cnt  <= NSLICE;
      mdl_have <= 1'b0;
    end else if (abort && (mdl_cnt > 0 || mdl_valid)) begin
      mdl_cnt   <= 0;
      mdl_valid <= 1'b0;
      mdl_rdy   <= 1'b1;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_valid <= 1'b1;
        mdl_res   <= pend_res;
        mdl_have  <= 1'b1;
      end
    end else if (mdl_valid) begin
      if (out_ready) begin
        mdl_valid <= 1'b0;
        mdl_rdy   <= 1'b1;
      end
    end else if (!mdl_rdy) begin
      mdl_rdy <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("mon_in_ready", 128'(in_ready), 128'(mdl_rdy));
        chk("mon_out_valid", 128'(out_valid), 128'(mdl_valid));
        if (mdl_have) chk("mon_result", 128'({ovf, zero, cout, sum}), 128'(mdl_res));
      end
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic c);
    int n;
    in_valid = 1'b1; op_a = a; op_b = b; sub = s; cin = c;
    for (n = 0; n < 20; n++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (n == 20) chk("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    // Scramble inputs: the DUT must ignore them after the accept edge.
    in_valid = 1'b0;
    op_a = {$urandom(), $urandom()};
    op_b = {$urandom(), $urandom()};
    sub = ~s; cin = ~c;
  endtask

  task automatic wait_res(input string name, input logic [WIDTH-1:0] es,
                          input logic ec, input logic eo, input logic ez,
                          input logic pop);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk({name, "_latency"}, 128'(lat), 128'(NSLICE));
    chk({name, "_sum"}, 128'(sum), 128'(es));
    chk({name, "_flags"}, 128'({cout, ovf, zero}), 128'({ec, eo, ez}));
    if (pop) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, "_drop"}, 128'(out_valid), 128'(0));
    end
  endtask

  task automatic do_op(input string name, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic s, input logic c,
                       input logic [WIDTH-1:0] es, input logic ec,
                       input logic eo, input logic ez);
    send(a, b, s, c);
    wait_res(name, es, ec, eo, ez, 1'b1);
  endtask

  task automatic run_tests();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    #1;
    chk("reset_outputs", 128'({in_ready, out_valid, cout, ovf, zero, sum}), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 128'(in_ready), 128'(1));

    do_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    do_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h0, 1'b1, 1'b0, 1'b1);
    do_op("sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    do_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_op("add_cin", 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
          64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    do_op("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0,
          64'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure in DONE with a new request pending.
    send(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    wait_res("bp_first", 64'h1212_2323_3434_4545, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; op_a = 64'hFF; op_b = 64'h1; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_sum", 128'(sum), 128'(64'h1212_2323_3434_4545));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", 128'(in_ready), 128'(1));
    chk("bp_idle_sum", 128'(sum), 128'(64'h1212_2323_3434_4545));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_taken", 128'(in_ready), 128'(0));
    wait_res("bp_second", 64'h100, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset during slice 2.
    send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_reset", 128'({in_ready, out_valid, cout, ovf, zero, sum}), 128'(0));
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midrun", 128'(in_ready), 128'(1));
    do_op("post_reset", 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0, 1'b0);

`ifdef WIDE_ADD_SEQ_ABORT_EN
    send(64'h10, 64'h20, 1'b0, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 128'(out_valid), 128'(0));
    end
    do_op("post_abort", 64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
`endif
    repeat (2) @(posedge clk);
  endtask

  initial begin
    fork
      monitor();
      run_tests();
      begin
        repeat (5000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL global_timeout: got running expected finished");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-precision add/subtract sequencer built on one lcu16 16-bit carry-lookahead adder instance.
- Accepts WIDTH-bit operands through a valid/ready handshake and processes one 16-bit slice per cycle, least-significant slice first.
- Registers the carry between slices and presents the full result with status flags on a valid/ready output.
- Serves narrow-datapath units that need 32/64/128-bit add/sub without replicating the adder.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of 16 and >= 16.
- Derived NSLICE = WIDTH/16 (local, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- sub  input  1  1: A-B; 0: A+B+cin.
- cin  input  1  carry-in for add; ignored when sub=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - State goes to IDLE.
  - Operand, result and carry registers, and the slice counter, clear to 0.
  - in_ready=0 while rst_n=0; in_ready=1 from the first clk edge after rst_n deasserts.
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a into A_reg. Latch B_reg = sub ? ~op_b : op_b. Set carry_reg = sub ? 1 : cin.
  - Same edge: slice counter k=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the lcu16 instance adds A_reg[16k+15:16k] + B_reg[16k+15:16k] + carry_reg.
  - The slice result is written to sum_reg[16k+15:16k] and c16 to carry_reg, then k++.
  - On the edge that processes slice NSLICE-1:
    - cout <= c16.
    - ovf <= (A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (slice sum bit15 != A_reg[WIDTH-1]).
    - zero <= (all earlier slices zero) && (final slice zero).
    - Go to DONE.
  - The zero flag is accumulated per slice in a register; no WIDTH-wide reduction is allowed.
- DONE:
  - out_valid=1; sum, cout, ovf and zero hold stable.
  - On out_valid&out_ready, go to IDLE. out_valid drops the next cycle; sum and flags stay at their last values until the next result overwrites them.
- Latency: out_valid rises exactly NSLICE cycles after the accepting edge.
  - Minimum initiation interval is NSLICE+2 cycles: accept, NSLICE RUN cycles, DONE, IDLE.
  - No back-to-back accept from DONE.
- Inputs op_a, op_b, sub and cin are sampled only on the accept edge. Changes afterwards have no effect.
- in_valid while busy is ignored: no queueing, no error flag.
- The lcu16 pg/gg outputs are unused.
- WIDTH=16 case: RUN lasts one cycle.
- Wrap-around: a full-width carry out sets cout=1 and sum wraps modulo 2^WIDTH.

Optional Feature:
- Macro: WIDE_ADD_SEQ_ABORT_EN.
- With the macro defined:
  - Extra input port abort (1 bit).
  - abort=1 in RUN or DONE: on the next edge go to IDLE, out_valid=0, carry and counter cleared, sum_reg retains partial contents. No result is delivered.
  - abort in IDLE has no effect.
  - abort has priority over out_ready in DONE.
  - abort is ignored on the same edge as an accept; an accept takes precedence.
- Without the macro: no abort port; an operation always runs to DONE.

Test Plan (WIDTH=64, NSLICE=4):
- Add across one slice boundary:
  - Stimulus: a=0x000000000000FFFF, b=0x1, sub=0, cin=0.
  - Expect: sum=0x0000000000010000, cout=0, ovf=0, zero=0.
  - Expect: out_valid high exactly 4 cycles after the accept edge.
- Full-width carry:
  - Stimulus: a=0xFFFFFFFFFFFFFFFF, b=0x1, add.
  - Expect: sum=0, cout=1, zero=1, ovf=0.
- Subtract with borrow:
  - Stimulus: a=5, b=7, sub=1, cin=1 (cin ignored).
  - Expect: sum=0xFFFFFFFFFFFFFFFE, cout=0, ovf=0.
- Signed overflow and wrap:
  - Stimulus: a=0x7FFFFFFFFFFFFFFF, b=1, add.
  - Expect: sum=0x8000000000000000, ovf=1, cout=0.
  - Stimulus: subtract a=0x8000000000000000, b=1.
  - Expect: sum=0x7FFFFFFFFFFFFFFF, ovf=1, cout=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
  - Expect: sum and flags stable, in_ready=0, new op not taken.
  - Expect: after out_ready=1, IDLE, then the new op is accepted.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 during slice 2.
  - Expect: all outputs 0 immediately (asynchronous).
  - Expect: after release, add a=0x1234, b=0x4321 gives sum=0x5555 correctly.
  - With WIDE_ADD_SEQ_ABORT_EN: abort in RUN returns to IDLE with no out_valid pulse.
